// File: rtl/wimax_randomizer_par_if.sv
// Stream and control bundle for wimax_randomizer_par.
// The master drives the input word, the output-side ready, and the seed controls.
// The slave (the randomizer) drives in_ready, the output word and word_cnt.
//   in_data/in_valid/in_last/in_ready     : upstream word handshake
//   out_data/out_valid/out_last/out_ready : downstream word handshake
//   rand_iv/reload                        : seed value and one-cycle load strobe
//   bypass                                : pass the accepted word unscrambled
//   word_cnt                              : words accepted in the current burst
interface wimax_randomizer_par_if #(
  parameter int DW    = 8,
  parameter int CNT_W = 16
);
  logic [DW-1:0]    in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [DW-1:0]    out_data;
  logic             out_valid;
  logic             out_last;
  logic             out_ready;
  logic [14:0]      rand_iv;
  logic             reload;
  logic             bypass;
  logic [CNT_W-1:0] word_cnt;

  modport master (
    output in_data, in_valid, in_last, out_ready, rand_iv, reload, bypass,
    input  in_ready, out_data, out_valid, out_last, word_cnt
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready, rand_iv, reload, bypass,
    output in_ready, out_data, out_valid, out_last, word_cnt
  );
endinterface

// File: rtl/wimax_randomizer_par.sv
// Word-parallel 802.16 OFDM randomizer, PRBS 1 + x^14 + x^15, DW bits per clock.
// Bit DW-1 of each word is the first bit on air and takes the first keystream bit.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : wimax_randomizer_par_if slave (handshakes, seed controls, word_cnt)
// A single output register stage gives 1-cycle latency and full throughput.
// in_ready depends only on out_valid and out_ready, and out_data is purely
// registered, so nothing combinational runs from out_ready to out_data.
module wimax_randomizer_par #(
  parameter int DW    = 8,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  wimax_randomizer_par_if.slave  bus
);

  // LFSR bit order: lfsr[14] = s1 ... lfsr[0] = s15, which matches rand_iv
  // directly (bit 14 loads s1, bit 0 loads s15).
  logic [14:0]      lfsr;
  logic [14:0]      seed_q;
  logic [CNT_W-1:0] cnt_q;
  logic [DW-1:0]    out_data_q;
  logic             out_valid_q;
  logic             out_last_q;

  logic             accept;
  logic [14:0]      work_st;
  logic [14:0]      step_st;
  logic [DW-1:0]    scr_data;
  logic             fb;

  assign bus.in_ready  = !out_valid_q || bus.out_ready;
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.word_cnt  = cnt_q;

  // A reload in the accept cycle seeds the word being accepted, so the
  // starting state is chosen before the DW serial steps are unrolled.
  always_comb begin
    work_st  = bus.reload ? bus.rand_iv : lfsr;
    step_st  = work_st;
    scr_data = bus.in_data;
    fb       = 1'b0;
    for (int j = 0; j < DW; j++) begin
      fb                = step_st[1] ^ step_st[0];
      scr_data[DW-1-j]  = bus.in_data[DW-1-j] ^ fb;
      step_st           = {fb, step_st[14:1]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr        <= '0;
      seed_q      <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      if (accept) begin
        out_data_q  <= bus.bypass ? bus.in_data : scr_data;
        out_valid_q <= 1'b1;
        out_last_q  <= bus.in_last;
        if (bus.in_last) begin
          // End of burst: restart from the latched seed, or from the seed
          // being latched this very cycle.
          lfsr  <= bus.reload ? bus.rand_iv : seed_q;
          cnt_q <= '0;
        end else begin
          lfsr  <= bus.bypass ? work_st : step_st;
          cnt_q <= (bus.reload ? '0 : cnt_q) + 1'b1;
        end
      end else begin
        if (bus.out_ready) begin
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
        end
        // Also covers a stall: the held output is untouched.
        if (bus.reload) begin
          lfsr  <= bus.rand_iv;
          cnt_q <= '0;
        end
      end
      if (bus.reload) begin
        seed_q <= bus.rand_iv;
      end
    end
  end

endmodule

// File: tb/tb_wimax_randomizer_par.sv
module tb_wimax_randomizer_par;

  typedef struct {
    logic [7:0] d;
    logic       l;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wimax_randomizer_par_if #(.DW(8), .CNT_W(16)) bus8 ();
  wimax_randomizer_par_if #(.DW(1), .CNT_W(16)) bus1 ();

  wimax_randomizer_par #(.DW(8), .CNT_W(16)) u8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8)
  );

  wimax_randomizer_par #(.DW(1), .CNT_W(16)) u1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  exp_t       q8[$];
  exp_t       q1[$];
  logic [7:0] cap8[$];
  logic       cap1[$];

  // Serial reference: s[1..15], b = s14 ^ s15, s1 <= b, sk <= s(k-1).
  logic [1:15] m_s;
  logic [14:0] m_seed;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  task automatic model_load(input logic [14:0] iv);
    for (int k = 1; k <= 15; k++) m_s[k] = iv[15-k];
    m_seed = iv;
  endtask

  task automatic model_word(input int n, input logic [31:0] d, input logic last,
                            input logic byp, input logic rld, input logic [14:0] iv,
                            output logic [31:0] o);
    logic b;
    if (rld) model_load(iv);
    o = d;
    if (!byp) begin
      for (int j = 0; j < n; j++) begin
        b = m_s[14] ^ m_s[15];
        o[n-1-j] = d[n-1-j] ^ b;
        for (int k = 15; k >= 2; k--) m_s[k] = m_s[k-1];
        m_s[1] = b;
      end
    end
    if (last) begin
      for (int k = 1; k <= 15; k++) m_s[k] = m_seed[15-k];
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send8(input logic [7:0] d, input logic last, input logic byp,
                       input logic rld, input logic [14:0] iv, input bit use_exp,
                       input logic [7:0] exp_d, input int exp_cnt);
    logic [31:0] m;
    exp_t        e;
    bit          ok;
    bus8.in_data  = d;
    bus8.in_last  = last;
    bus8.bypass   = byp;
    bus8.reload   = rld;
    bus8.rand_iv  = iv;
    bus8.in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus8.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("send8_in_ready");
    if (exp_cnt >= 0) chk("word_cnt", 32'(bus8.word_cnt), exp_cnt);
    model_word(8, {24'h0, d}, last, byp, rld, iv, m);
    e.d = use_exp ? exp_d : m[7:0];
    e.l = last;
    q8.push_back(e);
    @(posedge clk);
    #1;
    bus8.in_valid = 1'b0;
    bus8.in_last  = 1'b0;
    bus8.bypass   = 1'b0;
    bus8.reload   = 1'b0;
  endtask

  task automatic send1(input logic d, input logic rld, input logic [14:0] iv);
    logic [31:0] m;
    exp_t        e;
    bit          ok;
    bus1.in_data  = d;
    bus1.reload   = rld;
    bus1.rand_iv  = iv;
    bus1.in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus1.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("send1_in_ready");
    model_word(1, {31'h0, d}, 1'b0, 1'b0, rld, iv, m);
    e.d = {7'h0, m[0]};
    e.l = 1'b0;
    q1.push_back(e);
    @(posedge clk);
    #1;
    bus1.in_valid = 1'b0;
    bus1.reload   = 1'b0;
  endtask

  task automatic do_reload8(input logic [14:0] iv);
    bus8.reload  = 1'b1;
    bus8.rand_iv = iv;
    model_load(iv);
    @(posedge clk);
    #1;
    bus8.reload = 1'b0;
  endtask

  task automatic drain;
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      if (q8.size() == 0 && q1.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
    if (!ok) fail_now("drain");
  endtask

  // Monitors: a transfer seen at the negedge completes on the following posedge.
  always @(negedge clk) begin
    if (!reset && bus8.out_valid && bus8.out_ready) begin
      cap8.push_back(bus8.out_data);
      if (q8.size() == 0) begin
        fail_now("out8_unexpected");
      end else begin
        exp_t e;
        e = q8.pop_front();
        chk("out8_data", 32'(bus8.out_data), 32'(e.d));
        chk("out8_last", 32'(bus8.out_last), 32'(e.l));
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && bus1.out_valid && bus1.out_ready) begin
      cap1.push_back(bus1.out_data[0]);
      if (q1.size() == 0) begin
        fail_now("out1_unexpected");
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("out1_data", 32'(bus1.out_data), 32'(e.d[0]));
      end
    end
  end

  logic [7:0] rnd[16];
  logic [7:0] sd[12];
  logic [7:0] held;
  int         base_a;
  int         base_b;
  int         base8;
  logic [7:0] asm_byte;

  initial begin
    reset         = 1'b1;
    bus8.in_data  = '0;
    bus8.in_valid = 1'b0;
    bus8.in_last  = 1'b0;
    bus8.out_ready = 1'b1;
    bus8.rand_iv  = '0;
    bus8.reload   = 1'b0;
    bus8.bypass   = 1'b0;
    bus1.in_data  = '0;
    bus1.in_valid = 1'b0;
    bus1.in_last  = 1'b0;
    bus1.out_ready = 1'b1;
    bus1.rand_iv  = '0;
    bus1.reload   = 1'b0;
    bus1.bypass   = 1'b0;
    m_s    = '0;
    m_seed = '0;

    #12;
    chk("rst_out_valid", 32'(bus8.out_valid), 0);
    chk("rst_out_data",  32'(bus8.out_data), 0);
    chk("rst_out_last",  32'(bus8.out_last), 0);
    chk("rst_word_cnt",  32'(bus8.word_cnt), 0);
    chk("rst_in_ready",  32'(bus8.in_ready), 1);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Keystream from all-ones seed, zero data.
    do_reload8(15'h7FFF);
    send8(8'h00, 0, 0, 0, 15'h0, 1, 8'h00, 0);
    send8(8'h00, 0, 0, 0, 15'h0, 1, 8'h02, 1);
    send8(8'h00, 0, 0, 0, 15'h0, 1, 8'h00, 2);
    send8(8'h00, 0, 0, 0, 15'h0, 1, 8'h0C, 3);
    for (int i = 4; i < 64; i++) send8(8'h00, 0, 0, 0, 15'h0, 0, 8'h00, i);
    drain();

    // Burst reseed from the latched seed.
    do_reload8(15'h7FFF);
    bus8.rand_iv = 15'h1234;
    send8(8'h00, 0, 0, 0, 15'h1234, 1, 8'h00, 0);
    send8(8'h00, 0, 0, 0, 15'h1234, 1, 8'h02, 1);
    send8(8'h00, 1, 0, 0, 15'h1234, 1, 8'h00, 2);
    @(negedge clk);
    chk("cnt_after_last", 32'(bus8.word_cnt), 0);
    @(posedge clk);
    #1;
    send8(8'h00, 0, 0, 0, 15'h1234, 1, 8'h00, 0);
    send8(8'h00, 0, 0, 0, 15'h1234, 1, 8'h02, 1);
    drain();

    // Bypass keeps the keystream position.
    do_reload8(15'h7FFF);
    send8(8'h00, 0, 0, 0, 15'h0, 1, 8'h00, 0);
    send8(8'hA5, 0, 1, 0, 15'h0, 1, 8'hA5, 1);
    send8(8'h00, 0, 0, 0, 15'h0, 1, 8'h02, 2);
    drain();

    // Reload coincident with accept seeds that word.
    send8(8'h00, 0, 0, 1, 15'h7FFF, 1, 8'h00, -1);
    send8(8'h00, 0, 0, 0, 15'h7FFF, 1, 8'h02, 1);
    drain();

    // Backpressure: unstalled reference run, then the same run with a stall.
    for (int i = 0; i < 12; i++) sd[i] = 8'($urandom_range(0, 255));
    do_reload8(15'h3715);
    base_a = cap8.size();
    for (int i = 0; i < 12; i++) send8(sd[i], 0, 0, 0, 15'h0, 0, 8'h00, -1);
    drain();
    do_reload8(15'h3715);
    base_b = cap8.size();
    fork
      begin
        for (int i = 0; i < 12; i++) send8(sd[i], 0, 0, 0, 15'h0, 0, 8'h00, -1);
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        bus8.out_ready = 1'b0;
        @(negedge clk);
        held = bus8.out_data;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          chk("stall_in_ready",  32'(bus8.in_ready), 0);
          chk("stall_out_valid", 32'(bus8.out_valid), 1);
          chk("stall_out_data",  32'(bus8.out_data), 32'(held));
        end
        @(posedge clk);
        #1;
        bus8.out_ready = 1'b1;
      end
    join
    drain();
    for (int i = 0; i < 12; i++)
      chk("stall_vs_unstalled", 32'(cap8[base_b+i]), 32'(cap8[base_a+i]));

    // Serial equivalence: DW=8 against DW=1 on the same bits and seed.
    for (int i = 0; i < 16; i++) rnd[i] = 8'($urandom_range(0, 255));
    base8 = cap8.size();
    for (int i = 0; i < 16; i++) send8(rnd[i], 0, 0, (i == 0), 15'h3715, 0, 8'h00, -1);
    drain();
    for (int k = 0; k < 128; k++) send1(rnd[k/8][7-(k%8)], (k == 0), 15'h3715);
    drain();
    for (int i = 0; i < 16; i++) begin
      asm_byte = '0;
      for (int b = 0; b < 8; b++) asm_byte[7-b] = cap1[i*8+b];
      chk("dw1_vs_dw8", 32'(asm_byte), 32'(cap8[base8+i]));
    end

    // Async reset mid-burst clears state without a clock edge.
    do_reload8(15'h7FFF);
    send8(8'h00, 0, 0, 0, 15'h0, 1, 8'h00, 0);
    send8(8'h00, 0, 0, 0, 15'h0, 1, 8'h02, 1);
    #2;
    reset = 1'b1;
    q8.delete();
    m_s    = '0;
    m_seed = '0;
    #1;
    chk("arst_out_valid", 32'(bus8.out_valid), 0);
    chk("arst_word_cnt",  32'(bus8.word_cnt), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Zero state after reset: all-zero keystream passes data through.
    send8(8'hA5, 0, 0, 0, 15'h0, 1, 8'hA5, 0);
    send8(8'h3C, 1, 0, 0, 15'h0, 1, 8'h3C, 1);
    drain();

    chk("queues_empty", 32'(q8.size() + q1.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
